seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Reader side of the data memory's display-word output.
- Takes the packed 32-bit nibble word produced by the MEM-stage data memory (8 nibbles, addresses 3,7,…,31).
- Captures it into a shadow register through a req/ack handshake, then time-multiplexes it onto an 8-digit common-anode seven-segment display.
- Sits at the top level between the processor core and the board pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit; legal range ≥2.
- LZ_BLANK, 1, 1 = blank leading-zero digits; 0 = show all 8 digits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data_i  input  32  packed display word; nibble k = data_i[4k+3:4k].
- load_req_i  input  1  capture request, level; held until ack.
- hold_i  input  1  1 = refuse captures; scanning continues.
- load_ack_o  output  1  one-cycle pulse, shadow register updated this edge.
- an_o  output  8  digit enables, active low; an_o[k] = digit k (k=7 is leftmost).
- seg_o  output  7  {g,f,e,d,c,b,a}, active low.
- frame_done_o  output  1  one-cycle pulse when digit 7 finishes.

Behaviour:
- Reset (async assert, sync release) sets: state=IDLE, shadow=0, div=0, digit=0, an_o=8'hFF, seg_o=7'h7F, load_ack_o=0, frame_done_o=0.
- All outputs are registered.
- IDLE state:
  - Display is dark (an_o=FF, seg_o=7F).
  - At any edge with load_req_i=1 and hold_i=0: shadow<=data_i, load_ack_o=1 for that cycle, state->SCAN, div=0, digit=0.
- SCAN state:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - At div terminal, digit <= digit+1 (mod 8).
  - At div terminal with digit=7, frame_done_o pulses for one cycle.
  - Capture is allowed only on that same edge (frame boundary), if load_req_i=1 and hold_i=0. Then shadow<=data_i and load_ack_o pulses. This prevents tearing.
  - Outside the boundary, a request stays pending with no ack.
- Registered outputs in SCAN:
  - an_o = ~(1<<digit).
  - seg_o = hex decode of shadow nibble[digit]; decode is applied to the post-update digit and shadow, so a new frame shows new data from digit 0.
- Hex decode (active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k is blanked (an_o bit stays 1, seg_o=7F) when every nibble j≥k is zero and k≠0.
  - Digit 0 is always shown, so value 0 displays "0".
- Handshake:
  - Requester drops load_req_i the cycle after load_ack_o.
  - If load_req_i is still high after ack, it is a new request, served at the next frame boundary (or immediately in IDLE).
- hold_i=1:
  - No capture and no ack.
  - div, digit and frame_done_o run unchanged.
  - When hold_i falls, any pending request is served at the next eligible edge.
- No return from SCAN to IDLE except via reset.
- A reset asserted mid-frame or mid-handshake drops everything to the reset values immediately. A pending request is lost and must be re-asserted.
- Latency:
  - Request in IDLE: ack and new digit-0 image on the first edge.
  - Request in SCAN: worst case 8·REFRESH_DIV cycles.
- Only the 4 LSBs of each nibble are used; no other arithmetic.

Test Plan:
- REFRESH_DIV=4 in all tests, so a frame is 32 cycles.
- Reset then idle 50 cycles -> an_o=FF, seg_o=7F, load_ack_o=0, frame_done_o never pulses.
- IDLE, data_i=32'h1234ABCD, req for 1 cycle -> ack on the first edge; then an_o=FE with seg_o=0100001 (d) for 4 cycles, then FD with C, FB with b, F7 with A; an_o=7F shows 1 (1111001); frame_done_o pulses every 32 cycles.
- SCAN showing 1234ABCD, req with 32'hFFFFFFFF raised mid-frame (digit 3) -> no ack until the digit-7 terminal edge; ack coincides with frame_done_o; the next digit 0 shows F (0001110).
- LZ_BLANK=1, capture 32'h00000050 -> digits 7..2 dark (an bit high); digit 1 shows 5 (0010010); digit 0 shows 0 (1000000). Capture 0 -> only digit 0 lit, showing "0".
- hold_i=1 with req high for 3 frames -> no ack and shadow unchanged; frame_done_o still pulses. Drop hold_i -> ack at the next frame boundary.
- Assert rst_n low mid-frame with req pending -> an_o=FF, seg_o=7F, ack=0 in the same cycle (async); after release the module is in IDLE and the next req is acked on the first edge.

Source files
------------

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - tear-free capture of the display word and 8-digit seven-segment scan
// Captures are only taken at a frame boundary (or at once while idle), so a frame never mixes two words.
module seg_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_i,
  input  logic        load_req_i,
  input  logic        hold_i,
  output logic        load_ack_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_done_o
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [31:0]      shadow, shadow_n;
  logic [DIV_W-1:0] div, div_n;
  logic [2:0]       digit, digit_n;
  logic [7:0]       an_n;
  logic [6:0]       seg_n;
  logic             ack_n, frame_n;
  logic             capture, div_term, blank;
  logic [31:0]      upper;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    div_n    = div;
    digit_n  = digit;
    ack_n    = 1'b0;
    frame_n  = 1'b0;
    an_n     = 8'hFF;
    seg_n    = 7'h7F;
    capture  = 1'b0;
    blank    = 1'b0;
    upper    = 32'h0;
    div_term = (div == DIV_LAST);

    case (state)
      IDLE: begin
        if (load_req_i && !hold_i) begin
          capture = 1'b1;
          state_n = SCAN;
          div_n   = '0;
          digit_n = '0;
        end
      end
      default: begin
        div_n = div_term ? '0 : div + DIV_W'(1);
        if (div_term) begin
          digit_n = digit + 3'd1;
          frame_n = (digit == 3'd7);
        end
        capture = frame_n && load_req_i && !hold_i;
      end
    endcase

    if (capture) begin
      shadow_n = data_i;
      ack_n    = 1'b1;
    end

    // Image is built from the post-edge digit and shadow so a fresh capture shows from digit 0.
    if (state_n == SCAN) begin
      upper = shadow_n >> {digit_n, 2'b00};
      blank = LZ_BLANK && (digit_n != 3'd0) && (upper == 32'h0);
      if (!blank) begin
        an_n  = ~(8'd1 << digit_n);
        seg_n = hex7(upper[3:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= 32'h0;
      div          <= '0;
      digit        <= 3'd0;
      an_o         <= 8'hFF;
      seg_o        <= 7'h7F;
      load_ack_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      shadow       <= shadow_n;
      div          <= div_n;
      digit        <= digit_n;
      an_o         <= an_n;
      seg_o        <= seg_n;
      load_ack_o   <= ack_n;
      frame_done_o <= frame_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - checks seg_scan_display against a frame-time reference model
module tb_seg_scan_display;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        req = 1'b0;
  logic        hold = 1'b0;

  logic       ack1, fd1, ack0, fd0;
  logic [7:0] an1, an0;
  logic [6:0] seg1, seg0;

  seg_scan_display #(.REFRESH_DIV(R), .LZ_BLANK(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_i(data), .load_req_i(req), .hold_i(hold),
    .load_ack_o(ack1), .an_o(an1), .seg_o(seg1), .frame_done_o(fd1));

  seg_scan_display #(.REFRESH_DIV(R), .LZ_BLANK(1'b0)) u_dut_nz (
    .clk(clk), .rst_n(rst_n), .data_i(data), .load_req_i(req), .hold_i(hold),
    .load_ack_o(ack0), .an_o(an0), .seg_o(seg0), .frame_done_o(fd0));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference: edges elapsed since entering SCAN; digit and frame follow from plain division.
  bit          m_scan = 1'b0;
  logic [31:0] m_shadow = 32'h0;
  int          m_tick = 0;
  bit          m_ack = 1'b0;
  bit          m_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_scan = 1'b0; m_shadow = 32'h0; m_tick = 0; m_ack = 1'b0; m_frame = 1'b0;
    end else if (!m_scan) begin
      m_frame = 1'b0;
      m_ack = req && !hold;
      if (m_ack) begin
        m_scan = 1'b1; m_shadow = data; m_tick = 0;
      end
    end else begin
      m_tick++;
      m_frame = (m_tick % (8 * R)) == 0;
      m_ack = m_frame && req && !hold;
      if (m_ack) m_shadow = data;
    end
  endtask

  function automatic logic [14:0] image(input bit lz);
    int d;
    logic [31:0] up;
    logic [7:0] an;
    if (!m_scan) return {8'hFF, 7'h7F};
    d = (m_tick / R) % 8;
    up = m_shadow >> (4 * d);
    if (lz && d != 0 && up == 32'h0) return {8'hFF, 7'h7F};
    an = ~(8'd1 << d);
    return {an, tbl[up[3:0]]};
  endfunction

  task automatic check_all();
    logic [14:0] i1, i0;
    i1 = image(1'b1);
    i0 = image(1'b0);
    chk("an_lz", an1, i1[14:7]);
    chk("seg_lz", seg1, i1[6:0]);
    chk("an_nolz", an0, i0[14:7]);
    chk("seg_nolz", seg0, i0[6:0]);
    chk("ack", ack1, m_ack);
    chk("ack_nolz", ack0, m_ack);
    chk("frame", fd1, m_frame);
    chk("frame_nolz", fd0, m_frame);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (m_ack) req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input int bound);
    int n;
    n = 0;
    while (ack1 !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("ack_within_bound", ack1, 1'b1);
  endtask

  initial begin
    run(2);
    rst_n = 1'b1;
    run(50);

    data = 32'h1234ABCD; req = 1'b1;
    step();
    chk("idle_ack_first_edge", ack1, 1'b1);
    chk("first_digit_an", an1, 8'hFE);
    chk("first_digit_d", seg1, 7'b0100001);
    run(40);

    for (int n = 0; n < 8 * R && ((m_tick / R) % 8) != 3; n++) step();
    data = 32'hFFFFFFFF; req = 1'b1;
    wait_ack(8 * R + 2);
    chk("ack_with_frame_done", fd1, 1'b1);
    chk("new_frame_F", seg1, 7'b0001110);
    run(5);

    data = 32'h00000050; req = 1'b1;
    wait_ack(8 * R + 2);
    run(8 * R);
    data = 32'h0; req = 1'b1;
    wait_ack(8 * R + 2);
    run(8 * R);

    hold = 1'b1; data = 32'hDEAD0001; req = 1'b1;
    run(3 * 8 * R);
    hold = 1'b0;
    wait_ack(8 * R + 2);
    run(10);

    data = 32'h00C0FFEE; req = 1'b1;
    rst_n = 1'b0;
    #1;
    model_edge();
    check_all();
    chk("async_rst_an", an1, 8'hFF);
    run(2);
    rst_n = 1'b1; data = 32'h87654321; req = 1'b1;
    step();
    chk("ack_after_reset", ack1, 1'b1);

    for (int c = 0; c < 3000; c++) begin
      if (!req && $urandom_range(0, 7) == 0) begin
        req = 1'b1;
        data = $urandom >> (4 * $urandom_range(0, 8));
      end
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #1;
        model_edge();
        check_all();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
